// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write-port arbiter.
// Requester numbering fixes the bit position in every per-requester vector.
package regfile_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned NUM_WR_REQ = 3;
    localparam int unsigned DATA_W     = 32;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_DBG  = 2;

    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie
// and moves to the other requester only when the caller reports an accept.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant the other requester takes priority.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU writeback, load return and
// debug/CSR writes; debug wins only on idle cycles or once it has starved.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_WR_REQ-1:0]           req_valid,
    output logic [NUM_WR_REQ-1:0]           req_ready,
    input  logic [NUM_WR_REQ*REG_IDX_W-1:0] req_reg,
    input  logic [NUM_WR_REQ*XLEN-1:0]      req_data,
    output logic                            write,
    output logic [REG_IDX_W-1:0]            write_reg,
    output logic [XLEN-1:0]                 write_data,
    output logic                            starved
);

    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

    logic [1:0]           rr_grant;
    logic                 rr_advance;
    logic                 force_dbg;
    logic [7:0]           starve_cnt_q, starve_cnt_d;
    logic                 transfer;
    logic [REG_IDX_W-1:0] sel_reg;
    logic [XLEN-1:0]      sel_data;
    logic                 write_q, write_d;
    logic [REG_IDX_W-1:0] write_reg_q;
    logic [XLEN-1:0]      write_data_q;

    assign starved   = (starve_cnt_q == StarveMax);
    assign force_dbg = starved && req_valid[REQ_DBG];

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset   (reset),
        .valid   (req_valid[REQ_LOAD:REQ_ALU]),
        .advance (rr_advance),
        .grant   (rr_grant)
    );

    // Nothing is accepted during reset, so no grant can be lost downstream.
    always_comb begin
        req_ready = '0;
        if (!reset) begin
            if (force_dbg) begin
                req_ready[REQ_DBG] = 1'b1;
            end else if (|rr_grant) begin
                req_ready[REQ_ALU]  = rr_grant[0];
                req_ready[REQ_LOAD] = rr_grant[1];
            end else begin
                req_ready[REQ_DBG] = req_valid[REQ_DBG];
            end
        end
    end

    assign rr_advance = req_ready[REQ_ALU] || req_ready[REQ_LOAD];
    assign transfer   = |req_ready;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        unique case (1'b1)
            req_ready[REQ_ALU]: begin
                sel_reg  = req_reg[REQ_ALU*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data[REQ_ALU*XLEN +: XLEN];
            end
            req_ready[REQ_LOAD]: begin
                sel_reg  = req_reg[REQ_LOAD*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data[REQ_LOAD*XLEN +: XLEN];
            end
            req_ready[REQ_DBG]: begin
                sel_reg  = req_reg[REQ_DBG*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data[REQ_DBG*XLEN +: XLEN];
            end
            default: begin
                sel_reg  = '0;
                sel_data = '0;
            end
        endcase
    end

    // Writes to x0 are accepted but never reach the register file.
    assign write_d = transfer && (sel_reg != '0);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req_valid[REQ_DBG] || req_ready[REQ_DBG]) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            starve_cnt_q <= '0;
        end else begin
            write_q      <= write_d;
            starve_cnt_q <= starve_cnt_d;
            if (write_d) begin
                write_reg_q  <= sel_reg;
                write_data_q <= sel_data;
            end
        end
    end

    assign write      = write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed checks of regfile_write_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  valid_s;
    wr_req_t     req_s [3];
    logic [2:0]  req_ready;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        starved;

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (valid_s),
        .req_ready  (req_ready),
        .req_reg    ({req_s[2].idx, req_s[1].idx, req_s[0].idx}),
        .req_data   ({req_s[2].data, req_s[1].data, req_s[0].data}),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .starved    (starved)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_rr;
    int          m_cnt;
    logic        m_write;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_known;
    logic [2:0]  last_ready;

    logic [2:0]  obs_ready;
    logic        obs_write, obs_starved;
    logic [4:0]  obs_reg;
    logic [31:0] obs_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] model_ready();
        if (reset) return 3'b000;
        if (m_cnt == int'(LIMIT) && valid_s[2]) return 3'b100;
        if (valid_s[0] && valid_s[1]) return (m_rr == 0) ? 3'b001 : 3'b010;
        if (valid_s[0]) return 3'b001;
        if (valid_s[1]) return 3'b010;
        if (valid_s[2]) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_update(input logic [2:0] g);
        int gi;
        gi = g[0] ? 0 : g[1] ? 1 : g[2] ? 2 : -1;
        if (reset) begin
            m_rr = 0; m_cnt = 0; m_write = 1'b0;
            m_reg = '0; m_data = '0; m_known = 1'b1;
            return;
        end
        m_write = 1'b0;
        if (gi >= 0) begin
            if (req_s[gi].idx != 5'd0) begin
                m_write = 1'b1;
                m_reg   = req_s[gi].idx;
                m_data  = req_s[gi].data;
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
        if (gi == 0) m_rr = 1;
        if (gi == 1) m_rr = 0;
        if (!valid_s[2] || gi == 2) m_cnt = 0;
        else if (m_cnt < int'(LIMIT)) m_cnt++;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [2:0] er;
        @(negedge clock);
        er          = model_ready();
        obs_ready   = req_ready;
        obs_write   = write;
        obs_reg     = write_reg;
        obs_data    = write_data;
        obs_starved = starved;
        chk("m_ready", obs_ready, er);
        chk("m_starved", obs_starved, (m_cnt == int'(LIMIT)));
        chk("m_write", obs_write, m_write);
        if (m_known) begin
            chk("m_write_reg", obs_reg, m_reg);
            chk("m_write_data", obs_data, m_data);
        end
        @(posedge clock);
        model_update(er);
        last_ready = er;
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_s[i].idx  = r;
        req_s[i].data = d;
    endtask

    initial begin
        m_rr = 0; m_cnt = 0; m_write = 0; m_reg = '0; m_data = '0; m_known = 1;
        last_ready = '0;
        reset   = 1'b1;
        valid_s = 3'b111;
        for (int i = 0; i < 3; i++) set_req(i, 5'd1, 32'h0);
        @(posedge clock); #1;

        // Reset holds everything off even with all requesters valid
        cycle(); cycle();
        chk("rst_ready", obs_ready, 3'b000);
        chk("rst_write", obs_write, 1'b0);
        chk("rst_reg", obs_reg, 5'd0);
        chk("rst_starved", obs_starved, 1'b0);

        // Round-robin between ALU and load
        reset   = 1'b0;
        valid_s = 3'b011;
        set_req(0, 5'd3, 32'hAAAA0003);
        set_req(1, 5'd4, 32'hBBBB0004);
        cycle(); chk("rr_g0", obs_ready, 3'b001); chk("rr_w0", obs_write, 1'b0);
        cycle(); chk("rr_g1", obs_ready, 3'b010); chk("rr_reg1", obs_reg, 5'd3);
        chk("rr_data1", obs_data, 32'hAAAA0003);
        cycle(); chk("rr_g2", obs_ready, 3'b001); chk("rr_reg2", obs_reg, 5'd4);
        chk("rr_data2", obs_data, 32'hBBBB0004);
        cycle(); chk("rr_g3", obs_ready, 3'b010); chk("rr_reg3", obs_reg, 5'd3);

        // Debug starves for LIMIT cycles, then wins
        valid_s = 3'b111;
        set_req(2, 5'd7, 32'h12345678);
        for (int i = 0; i < int'(LIMIT); i++) begin
            cycle();
            chk("stv_lose", obs_ready[2], 1'b0);
            chk("stv_not_starved", obs_starved, 1'b0);
        end
        cycle();
        chk("stv_grant", obs_ready, 3'b100);
        chk("stv_starved", obs_starved, 1'b1);
        valid_s = 3'b011;
        cycle();
        chk("stv_write", obs_write, 1'b1);
        chk("stv_reg", obs_reg, 5'd7);
        chk("stv_data", obs_data, 32'h12345678);
        chk("stv_clear", obs_starved, 1'b0);

        // x0 write is accepted, suppressed, and still moves the pointer
        valid_s = 3'b001;
        cycle();
        valid_s = 3'b010;
        set_req(1, 5'd0, 32'hFFFFFFFF);
        cycle(); chk("x0_ready", obs_ready, 3'b010);
        valid_s = 3'b011;
        set_req(1, 5'd4, 32'hBBBB0004);
        cycle(); chk("x0_nowrite", obs_write, 1'b0); chk("x0_rr", obs_ready, 3'b001);

        // Request coinciding with reset is dropped
        valid_s = 3'b001;
        set_req(0, 5'd5, 32'h00000055);
        reset = 1'b1;
        cycle(); chk("rstg_ready", obs_ready, 3'b000);
        cycle(); chk("rstg_write", obs_write, 1'b0); chk("rstg_reg", obs_reg, 5'd0);
        chk("rstg_data", obs_data, 32'h0);
        reset = 1'b0;
        cycle(); chk("rstg_regrant", obs_ready, 3'b001);
        valid_s = 3'b000;
        cycle(); chk("rstg_wr", obs_write, 1'b1); chk("rstg_wreg", obs_reg, 5'd5);

        // Idle holds the last written index and data
        valid_s = 3'b001;
        set_req(0, 5'd9, 32'h0000DEAD);
        cycle();
        valid_s = 3'b000;
        cycle(); chk("idle_w", obs_write, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("idle_nowrite", obs_write, 1'b0);
            chk("idle_reg", obs_reg, 5'd9);
            chk("idle_data", obs_data, 32'h0000DEAD);
        end

        // Random traffic: a requester keeps its request until accepted
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 3; i++) begin
                if (!(valid_s[i] && !last_ready[i])) begin
                    valid_s[i] = ($urandom_range(0, 99) < ((i == 2) ? 30 : 70));
                    set_req(i, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
